// File: rtl/program_loader.sv
// program_loader: boot-time writer for the instruction memory.
// Receives a byte stream (2-byte big-endian word count, then big-endian
// 32-bit words) over valid/ready and writes each assembled word to
// consecutive addresses starting at BASE_ADDR, holding the CPU in reset
// for the duration of the load.
module program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int BASE_ADDR  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Largest word count that still fits between BASE_ADDR and the top of memory,
  // so BASE_ADDR + idx can never wrap.
  localparam logic [31:0] MAX_WORDS = 32'((1 << ADDR_WIDTH) - BASE_ADDR);

  logic [2:0]            state_q,        state_d;
  logic [15:0]           count_q,        count_d;
  logic [DATA_WIDTH-1:0] word_q,         word_d;
  logic [1:0]            byte_cnt_q,     byte_cnt_d;
  logic [ADDR_WIDTH:0]   idx_q,          idx_d;
  logic                  mem_we_q,       mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,     mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q,     mem_data_d;
  logic                  done_q,         done_d;
  logic                  error_q,        error_d;
  logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;

  logic                  rx_ready_s;
  logic                  xfer_s;
  logic [15:0]           hdr_count_s;
  logic [DATA_WIDTH-1:0] word_next_s;

  // Handshake and datapath helpers decoded from the current state.
  always_comb begin
    rx_ready_s  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
    xfer_s      = rx_valid && rx_ready_s;
    hdr_count_s = {count_q[15:8], rx_data};
    word_next_s = {word_q[DATA_WIDTH-9:0], rx_data};
  end

  // Next-state and next-output logic of the load sequencer.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    word_d         = word_q;
    byte_cnt_d     = byte_cnt_q;
    idx_d          = idx_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    done_d         = 1'b0;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_HDR_HI;
          error_d        = 1'b0;
          words_loaded_d = '0;
          idx_d          = '0;
          byte_cnt_d     = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR_HI: begin
        if (xfer_s) begin
          count_d[15:8] = rx_data;
          state_d       = S_HDR_LO;
        end else begin
          state_d = S_HDR_HI;
        end
      end
      S_HDR_LO: begin
        if (xfer_s) begin
          count_d = hdr_count_s;
          if (hdr_count_s == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (32'(hdr_count_s) > MAX_WORDS) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else begin
            state_d    = S_DATA;
            byte_cnt_d = 2'd0;
          end
        end else begin
          state_d = S_HDR_LO;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          word_d = word_next_s;
          if (byte_cnt_q == 2'd3) begin
            // Registered write strobe: address/data are stable through WRITE.
            state_d    = S_WRITE;
            byte_cnt_d = 2'd0;
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_WIDTH'(BASE_ADDR) + idx_q[ADDR_WIDTH-1:0];
            mem_data_d = word_next_s;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        idx_d          = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        words_loaded_d = words_loaded_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if ((32'(idx_q) + 32'd1) == 32'(count_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      count_q        <= 16'd0;
      word_q         <= '0;
      byte_cnt_q     <= 2'd0;
      idx_q          <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      word_q         <= word_d;
      byte_cnt_q     <= byte_cnt_d;
      idx_q          <= idx_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign rx_ready     = rx_ready_s;
  assign cpu_hold     = (state_q != S_IDLE);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the 32-bit instruction memory. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses starting at `BASE_ADDR`. While loading, it holds the processor in reset through `cpu_hold`. It sits between the serial/host byte source and the write port of the instruction memory that the fetch stage reads synchronously.

## Interface
- `DATA_WIDTH`, 32: instruction word width. Fixed at 4 bytes; any other value is unsupported.
- `ADDR_WIDTH`, 9: instruction-memory address width (512 words).
- `BASE_ADDR`, 1: address of the first loaded word. The program's first instruction lives at address 1.

Ports:
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  begin a load; sampled only in IDLE.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_data`  out  DATA_WIDTH  write data.
- `cpu_hold`  out  1  high while a load is in progress; keeps the CPU in reset.
- `done`  out  1  one-cycle pulse when a load completes successfully.
- `error`  out  1  sticky flag for an oversize word count; cleared by the next accepted `start` or by reset.
- `words_loaded`  out  ADDR_WIDTH+1  number of words written in the current or last load.

## Operation
- **Byte transfer:** a byte transfers on any edge where `rx_valid && rx_ready`. Input bytes are not buffered beyond the assembly register.
- **Stream format:** 2-byte word count N (MSB first), then N×4 bytes. Each word is sent MSB byte first.
- **States and transitions:**
  - IDLE → HDR_HI when `start`=1.
  - HDR_HI → HDR_LO on a byte transfer (`count[15:8]`).
  - HDR_LO → on a byte transfer (`count[7:0]`):
    - if N==0, go to DONE;
    - if N > 2**ADDR_WIDTH − BASE_ADDR, set `error` and go to IDLE;
    - otherwise go to DATA.
  - DATA: shifts 4 bytes into `word` (`word <= {word[23:0], rx_data}`), counting bytes 0..3. The 4th byte transfer moves to WRITE.
  - WRITE: `mem_we`=1, `mem_addr`=BASE_ADDR+idx, `mem_data`=`word`. Then `idx`++ and `words_loaded`++. If `idx`+1==N go to DONE, else go to DATA.
  - DONE: `done`=1 for one cycle, then IDLE.
- **Output levels by state:**
  - `rx_ready`=1 only in HDR_HI, HDR_LO and DATA.
  - `cpu_hold`=1 in every state except IDLE.
- **`start` handling:** `start` outside IDLE is ignored. `start` in IDLE clears `error` and `words_loaded`.
- **Address arithmetic:** `BASE_ADDR`+`idx` is computed at ADDR_WIDTH bits. The N check guarantees it never wraps.
- **Stalls:** `rx_valid` low stalls any receiving state indefinitely; there is no timeout.
- **Reset values:** `rst_n`=0 forces IDLE with `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `cpu_hold`=0, `done`=0, `error`=0, `words_loaded`=0.
- **Reset mid-load:** words already written remain in memory. The partial word is discarded, and no write occurs in the reset cycle or after it.

## Timing
- `start` high at edge k → HDR_HI with `rx_ready`=1 from cycle k+1.
- With `rx_valid` held high: header takes 2 cycles, and each word takes 5 cycles (4 byte transfers + 1 WRITE cycle with `rx_ready`=0).
- The write occurs in the cycle after the 4th byte transfer. `mem_addr` and `mem_data` are registered and stable for the whole `mem_we` cycle.
- `done` is high in the cycle after the last WRITE cycle. `cpu_hold` falls in the following cycle, together with the return to IDLE.
- Full load of N words with no stalls: start to `done` = 1 + 2 + 5N cycles.
- **Simultaneous events:** `rst_n`=0 overrides everything. `start` coincident with DONE is ignored.

## Test plan
- **Six-word program, BASE_ADDR=1:** stream `00 06` then 24 bytes starting `07 E0 00 00`, `38 B0 00 00` → six `mem_we` pulses at addresses 1..6 with data 0x07E00000, 0x38B00000, …; `done` pulse; `words_loaded`=6; `cpu_hold` high from start through DONE.
- **Stalled source:** same stream with `rx_valid` toggled 1/0 every cycle → identical writes and data; byte transfers only on cycles where `rx_valid`=1; no extra or missing writes.
- **Zero count:** `00 00` → no `mem_we`; `done` 1 cycle after the HDR_LO transfer; `words_loaded`=0.
- **Oversize count:** `02 00` (512 > 511) → `error`=1 and IDLE; no `mem_we`, no `done`. A new `start` clears `error`.
- **Reset mid-load:** `rst_n`=0 after 2 words plus 2 bytes of the third → no further `mem_we`; all outputs at reset values next cycle. Restart and load 1 word → write at address 1.
- **Start while busy:** pulse `start` during DATA → ignored; the load continues unchanged.
